// File: rtl/prio_pkg.sv
// Shared types, defaults and helpers for the priority-encoder front end.
package prio_pkg;

    typedef enum logic {IDLE, OFFER} arb_state_t;

    localparam int N_REQ_DEF = 4;
    localparam int CNT_W_DEF = 8;

    // Index of the highest set bit; 0 when the vector is empty.
    function automatic int highest_idx(input logic [31:0] vec);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational highest-set-bit encoder with an any-bit-set flag (N up to 32).
module prio_enc_n
    import prio_pkg::*;
#(
    parameter int N     = N_REQ_DEF,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        any = |vec;
        idx = IDX_W'(highest_idx(32'(vec)));
    end

endmodule

// File: rtl/req_pend_arb.sv
// Sticky request capture with enable masking and a one-at-a-time valid/ready offer.
// Optional saturating drop counter built only when REQ_DROP_CNT_EN is defined.
module req_pend_arb
    import prio_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = $clog2(N_REQ),
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] enable,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready,
    output logic [N_REQ-1:0] pending,
    output logic [CNT_W-1:0] drop_cnt
);

    arb_state_t       state;
    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] rise;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] cand;
    logic [IDX_W-1:0] sel;
    logic             sel_any;
    logic             accept;

    assign accept = out_valid && out_ready;
    assign cand   = pending & enable;

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        rise = req & ~req_q;
        clr  = '0;
        if (accept) clr[out_idx] = 1'b1;
    end

    prio_enc_n #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_enc (
        .vec (cand),
        .idx (sel),
        .any (sel_any)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    // A rise on the bit being granted re-arms it: set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            pending <= '0;
        end else begin
            req_q   <= req;
            pending <= (pending & ~clr) | rise;
        end
    end

    // Offer is frozen until accepted; the return through IDLE forces the bubble cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_any) begin
                        out_idx   <= sel;
                        out_valid <= 1'b1;
                        state     <= OFFER;
                    end
                end
                OFFER: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef REQ_DROP_CNT_EN
    logic drop;

    // Any number of simultaneous losses in one cycle counts once.
    assign drop = |(rise & pending & ~clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_req_pend_arb.sv
// Self-checking bench for req_pend_arb: per-cycle behavioural model plus directed literal checks.
module tb_req_pend_arb;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic [3:0] req       = '0;
    logic [3:0] enable    = '0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [1:0] out_idx;
    logic [3:0] pending;
    logic [7:0] drop_cnt;

    int checks   = 0;
    int failures = 0;

`ifdef REQ_DROP_CNT_EN
    localparam bit DROP_ON = 1'b1;
`else
    localparam bit DROP_ON = 1'b0;
`endif

    req_pend_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .enable    (enable),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .pending   (pending),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_drop(input int n);
        if (!DROP_ON) return 0;
        return (n > 255) ? 255 : n;
    endfunction

    // Model: a set of outstanding requests, the index on offer (-1 = none), a loss tally.
    bit [3:0] m_pending  = '0;
    bit [3:0] m_req_prev = '0;
    int       m_offer    = -1;
    int       m_drop     = 0;

    function automatic int top_of(input bit [3:0] v);
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        bit [3:0] new_req;
        bit [3:0] granted;
        bit       taken;
        int       nxt;
        new_req = req & ~m_req_prev;
        taken   = (m_offer >= 0) && out_ready;
        granted = '0;
        if (taken) granted[m_offer] = 1'b1;
        if (DROP_ON && ((new_req & m_pending & ~granted) != 0) && (m_drop < 255)) m_drop = m_drop + 1;
        if (m_offer >= 0) nxt = taken ? -1 : m_offer;
        else              nxt = top_of(m_pending & enable);
        m_pending  = (m_pending & ~granted) | new_req;
        m_req_prev = req;
        m_offer    = nxt;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending  = '0;
            m_req_prev = '0;
            m_offer    = -1;
            m_drop     = 0;
        end else begin
            model_step();
            #2;
            if (rst_n) begin
                check("model_valid", 32'(out_valid), 32'(m_offer >= 0));
                if (m_offer >= 0) check("model_idx", 32'(out_idx), m_offer);
                check("model_pending", 32'(pending), 32'(m_pending));
                check("model_drop", 32'(drop_cnt), m_drop);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_offer(input string name, input logic [1:0] idx);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_idx"}, 32'(out_idx), 32'(idx));
    endtask

    initial begin
        int grants;

        // Reset state
        enable    = 4'hF;
        out_ready = 1'b1;
        cyc(2);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_idx", 32'(out_idx), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        rst_n = 1'b1;

        // 1: single source, two-cycle latency
        cyc(1); req = 4'b0100;
        cyc(1); req = 4'b0000;
        check("t1_pending", 32'(pending), 32'h4);
        check("t1_early_valid", 32'(out_valid), 0);
        cyc(1); expect_offer("t1_offer", 2'd2);
        cyc(1);
        check("t1_after_valid", 32'(out_valid), 0);
        check("t1_after_pending", 32'(pending), 0);
        check("t1_drop", 32'(drop_cnt), 0);

        // 2: priority and hold, then drain 3,1,0 with bubbles
        out_ready = 1'b0; req = 4'b1011;
        cyc(1); req = 4'b0000;
        check("t2_pending", 32'(pending), 32'hB);
        for (int i = 0; i < 5; i++) begin
            cyc(1); expect_offer("t2_hold", 2'd3);
        end
        out_ready = 1'b1;
        cyc(1);
        check("t2_bubble1", 32'(out_valid), 0);
        check("t2_pending1", 32'(pending), 32'h3);
        cyc(1); expect_offer("t2_g1", 2'd1);
        cyc(1); check("t2_bubble2", 32'(out_valid), 0);
        cyc(1); expect_offer("t2_g0", 2'd0);
        cyc(1);
        check("t2_done_valid", 32'(out_valid), 0);
        check("t2_done_pending", 32'(pending), 0);

        // 3: masking
        enable = 4'b0111; out_ready = 1'b0; req = 4'b1100;
        cyc(1); req = 4'b0000;
        check("t3_pending", 32'(pending), 32'hC);
        cyc(1); expect_offer("t3_masked", 2'd2);
        out_ready = 1'b1;
        cyc(1);
        check("t3_valid_a", 32'(out_valid), 0);
        check("t3_pending_a", 32'(pending), 32'h8);
        cyc(1);
        check("t3_valid_b", 32'(out_valid), 0);
        check("t3_pending_b", 32'(pending), 32'h8);
        enable = 4'hF;
        cyc(1); expect_offer("t3_unmask", 2'd3);
        cyc(1); check("t3_pending_c", 32'(pending), 0);

        // 4: held level gives one grant
        req = 4'b0010; grants = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            if (i == 10) req = 4'b0000;
            if (out_valid) grants++;
        end
        check("t4_grants", grants, 1);
        check("t4_drop0", 32'(drop_cnt), 0);
        check("t4_pending0", 32'(pending), 0);

        // 4: three lost pulses while bit 1 is held pending
        out_ready = 1'b0; req = 4'b0010;
        cyc(1); req = 4'b0000;
        cyc(1);
        for (int i = 0; i < 3; i++) begin
            req = 4'b0010; cyc(1);
            req = 4'b0000; cyc(1);
        end
        check("t4_drop3", 32'(drop_cnt), exp_drop(3));
        check("t4_pending1", 32'(pending), 32'h2);
        expect_offer("t4_offer", 2'd1);

        // 5: accept and re-request same bit on one edge
        out_ready = 1'b1; req = 4'b0010;
        cyc(1);
        check("t5_valid", 32'(out_valid), 0);
        check("t5_pending", 32'(pending), 32'h2);
        check("t5_drop", 32'(drop_cnt), exp_drop(3));
        out_ready = 1'b0; req = 4'b0000;
        cyc(1); expect_offer("t5_reoffer", 2'd1);

        // 4 (cont.): saturation
        for (int i = 0; i < 300; i++) begin
            req = 4'b0010; cyc(1);
            req = 4'b0000; cyc(1);
        end
        check("t4_drop_sat", 32'(drop_cnt), exp_drop(303));

        // 6: async reset mid-offer
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0; req = 4'b0100;
        cyc(1); req = 4'b0000;
        cyc(1); expect_offer("t6_offer", 2'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 0);
        check("t6_rst_pending", 32'(pending), 0);
        check("t6_rst_drop", 32'(drop_cnt), 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check("t6_post_valid", 32'(out_valid), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
